fifo_queue: RTL

Synchronous first-word-fall-through FIFO that buffers data words downstream of the latch_d data-holding stage. The latch stage holds a word while its enable is low. This block captures that word on a clock edge when `push` is high, then presents words in arrival order to the next emulator stage. It decouples the latch's level-sensitive hold window from a consumer that may stall for several cycles.

---
 rtl/fifo_queue.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_queue.sv
// First-word-fall-through FIFO buffering words captured from the latch_d stage.
// Optional feature macro: FIFO_OVERFLOW_COUNT_EN adds a saturating dropped-push counter.
module fifo_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         out,
  output logic                     empty,
  output logic                     full,
`ifdef FIFO_OVERFLOW_COUNT_EN
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               overflow_count
`else
  output logic [$clog2(DEPTH):0]   count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign count = count_q;
  assign out   = mem[rd_ptr];

  // A full queue still accepts a push when a pop frees the head slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

`ifdef FIFO_OVERFLOW_COUNT_EN
  // Saturates so a long stall cannot wrap back to a misleading small value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_count <= '0;
    end else if (drop && (overflow_count != 8'hFF)) begin
      overflow_count <= overflow_count + 8'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
